// File: rtl/deframer.sv
// deframer: unpacks a valid/ready byte stream into elements, counts a fixed
// number of payload elements per frame, and checks the two-byte tail that
// follows. A bad tail drops into a hunt state that discards bytes until the
// next tail pair, after which the next byte is payload byte 0.
//
// Handshake rules, both sides: a transfer happens on a rising clock edge when
// valid and ready are both high. valid never depends on ready. ready_o depends
// only on state, the remaining-element count and ready_i, never on valid_i.
// Once an element is offered, it stays stable until accepted.
module deframer #(
  parameter int          UnpackedWidth  = 1,
  parameter int          PackedNum      = 8,
  parameter int          PacketLenElems = 75684,
  parameter logic [7:0]  TailByte0      = 8'h0D,
  parameter logic [7:0]  TailByte1      = 8'h0A
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [UnpackedWidth*PackedNum-1:0]   data_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  output logic [UnpackedWidth-1:0]             unpacked_o,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic                                 last_o,
  output logic                                 frame_ok_o,
  output logic                                 frame_err_o
);

  localparam int BusWidth       = UnpackedWidth * PackedNum;
  localparam int PacketLenBytes = (PacketLenElems + PackedNum - 1) / PackedNum;
  localparam int LastByteElems  = PacketLenElems - (PacketLenBytes - 1) * PackedNum;

  localparam int RemW     = $clog2(PackedNum + 1);
  localparam int ByteCntW = $clog2(PacketLenBytes + 1);
  localparam int ElemCntW = $clog2(PacketLenElems + 1);

  localparam logic [RemW-1:0]     RemZero  = '0;
  localparam logic [RemW-1:0]     RemOne   = RemW'(1);
  localparam logic [RemW-1:0]     RemFull  = RemW'(PackedNum);
  localparam logic [RemW-1:0]     RemLast  = RemW'(LastByteElems);
  localparam logic [ByteCntW-1:0] ByteLast = ByteCntW'(PacketLenBytes - 1);
  localparam logic [ElemCntW-1:0] ElemLast = ElemCntW'(PacketLenElems - 1);

  localparam logic [BusWidth-1:0] Tail0Bus = BusWidth'(TailByte0);
  localparam logic [BusWidth-1:0] Tail1Bus = BusWidth'(TailByte1);

  typedef enum logic [1:0] {
    PAYLOAD = 2'd0,
    TAIL0   = 2'd1,
    TAIL1   = 2'd2,
    HUNT    = 2'd3
  } state_e;

  // Frame-level state.
  state_e                state_q, state_d;
  logic [ByteCntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic                  seen0_q, seen0_d;
  logic                  frame_ok_q, frame_ok_d;
  logic                  frame_err_q, frame_err_d;

  // Element holding register and output-side element count.
  logic [BusWidth-1:0]   hold_q, hold_d;
  logic [RemW-1:0]       rem_q, rem_d;
  logic [ElemCntW-1:0]   elem_cnt_q, elem_cnt_d;

  logic                  in_fire;
  logic                  out_fire;
  logic                  is_tail0;
  logic                  is_tail1;
  logic                  enter_hunt;

  // Byte-side ready: payload bytes wait for the holding register to empty,
  // allowing a reload in the same cycle its final element leaves. Tail and
  // hunt bytes never touch the holding register, so they are always taken.
  always_comb begin
    ready_o = 1'b1;
    if (state_q == PAYLOAD) begin
      ready_o = (rem_q == RemZero) | ((rem_q == RemOne) & ready_i);
    end
  end

  assign valid_o     = (rem_q != RemZero);
  assign unpacked_o  = hold_q[UnpackedWidth-1:0];
  assign last_o      = valid_o & (elem_cnt_q == ElemLast);
  assign frame_ok_o  = frame_ok_q;
  assign frame_err_o = frame_err_q;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;
  assign is_tail0 = (data_i == Tail0Bus);
  assign is_tail1 = (data_i == Tail1Bus);

  // Frame FSM: payload byte counting, tail check and hunt resynchronisation.
  // Only an accepted byte can move the state.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    seen0_d     = seen0_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    enter_hunt  = 1'b0;

    if (in_fire) begin
      unique case (state_q)
        PAYLOAD: begin
          if (byte_cnt_q == ByteLast) begin
            byte_cnt_d = '0;
            state_d    = TAIL0;
          end else begin
            byte_cnt_d = byte_cnt_q + ByteCntW'(1);
          end
        end
        TAIL0: begin
          if (is_tail0) begin
            state_d = TAIL1;
          end else begin
            frame_err_d = 1'b1;
            enter_hunt  = 1'b1;
          end
        end
        TAIL1: begin
          if (is_tail1) begin
            frame_ok_d = 1'b1;
            state_d    = PAYLOAD;
          end else begin
            frame_err_d = 1'b1;
            enter_hunt  = 1'b1;
          end
        end
        HUNT: begin
          if (is_tail0) begin
            seen0_d = 1'b1;
          end else if (is_tail1 && seen0_q) begin
            seen0_d    = 1'b0;
            byte_cnt_d = '0;
            state_d    = PAYLOAD;
          end else begin
            seen0_d = 1'b0;
          end
        end
        default: begin
          state_d = PAYLOAD;
        end
      endcase
    end

    // Hunting always starts from a clean slate.
    if (enter_hunt) begin
      state_d    = HUNT;
      byte_cnt_d = '0;
      seen0_d    = 1'b0;
    end
  end

  // Holding register: shift out one element per output handshake; a payload
  // byte reloads it. A reload only happens when the register is empty or is
  // emptying this cycle, so the load simply overrides the shift.
  always_comb begin
    hold_d = hold_q;
    rem_d  = rem_q;

    if (out_fire) begin
      hold_d = hold_q >> UnpackedWidth;
      rem_d  = rem_q - RemOne;
    end

    if (in_fire && (state_q == PAYLOAD)) begin
      hold_d = data_i;
      rem_d  = (byte_cnt_q == ByteLast) ? RemLast : RemFull;
    end
  end

  // Element counter drives last_o; it wraps on the final element of a frame
  // and restarts whenever hunting begins.
  always_comb begin
    elem_cnt_d = elem_cnt_q;
    if (out_fire) begin
      elem_cnt_d = (elem_cnt_q == ElemLast) ? '0 : (elem_cnt_q + ElemCntW'(1));
    end
    if (enter_hunt) begin
      elem_cnt_d = '0;
    end
  end

  // State register with asynchronous reset to an empty, payload-ready block.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= PAYLOAD;
      byte_cnt_q  <= '0;
      seen0_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      hold_q      <= '0;
      rem_q       <= '0;
      elem_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      seen0_q     <= seen0_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      hold_q      <= hold_d;
      rem_q       <= rem_d;
      elem_cnt_q  <= elem_cnt_d;
    end
  end

endmodule

// File: tb/tb_deframer.sv
// Bench for deframer: two instances (1-bit x 8 elements, 10 per frame; and
// 2-bit x 4 elements, 6 per frame) driven with directed and random byte
// streams and checked against a byte-level frame parser.
module tb_deframer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- DUT A: 1-bit elements ----------------
  logic [7:0] a_data_i;
  logic       a_valid_i, a_ready_o, a_unpacked_o, a_valid_o, a_ready_i;
  logic       a_last_o, a_ok, a_err;

  deframer #(.UnpackedWidth(1), .PackedNum(8), .PacketLenElems(10),
             .TailByte0(8'h0D), .TailByte1(8'h0A)) dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(a_data_i), .valid_i(a_valid_i),
    .ready_o(a_ready_o), .unpacked_o(a_unpacked_o), .valid_o(a_valid_o),
    .ready_i(a_ready_i), .last_o(a_last_o), .frame_ok_o(a_ok),
    .frame_err_o(a_err));

  // ---------------- DUT B: 2-bit elements ----------------
  logic [7:0] b_data_i;
  logic       b_valid_i, b_ready_o, b_valid_o, b_ready_i;
  logic [1:0] b_unpacked_o;
  logic       b_last_o, b_ok, b_err;

  deframer #(.UnpackedWidth(2), .PackedNum(4), .PacketLenElems(6),
             .TailByte0(8'h0D), .TailByte1(8'h0A)) dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(b_data_i), .valid_i(b_valid_i),
    .ready_o(b_ready_o), .unpacked_o(b_unpacked_o), .valid_o(b_valid_o),
    .ready_i(b_ready_i), .last_o(b_last_o), .frame_ok_o(b_ok),
    .frame_err_o(b_err));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  // entry = {last, element}
  logic [8:0] exp_q_a[$];
  logic [8:0] exp_q_b[$];
  // event codes: 1 = frame ok, 2 = frame error
  logic [1:0] ev_q_a[$];
  logic [1:0] ev_q_b[$];

  int a_last_cyc = -1, a_ok_cyc = -1, acc_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Byte-level parser: a frame is a fixed number of payload bytes followed by
  // two tail bytes; a bad tail means bytes are skipped until a 0D,0A pair.
  // phase: 0 payload, 1 expecting first tail, 2 expecting second tail, 3 skipping
  int m_phase[2];
  int m_bidx[2];
  int m_seen0[2];

  task automatic model_reset(input int inst);
    m_phase[inst] = 0;
    m_bidx[inst]  = 0;
    m_seen0[inst] = 0;
  endtask

  task automatic push_ev(input int inst, input logic [1:0] code);
    if (inst == 0) ev_q_a.push_back(code);
    else           ev_q_b.push_back(code);
  endtask

  task automatic model_accept(input int inst, input logic [7:0] b);
    int uw, pn, ple, plb, pos, bi, elem;
    logic [8:0] ent;
    uw  = (inst == 0) ? 1 : 2;
    pn  = (inst == 0) ? 8 : 4;
    ple = (inst == 0) ? 10 : 6;
    plb = (ple + pn - 1) / pn;
    bi  = int'(b);
    case (m_phase[inst])
      0: begin
        for (int k = 0; k < pn; k++) begin
          pos = m_bidx[inst] * pn + k;
          if (pos < ple) begin
            elem = (bi >> (k * uw)) & ((1 << uw) - 1);
            ent  = 9'(((pos == ple - 1) ? 256 : 0) + elem);
            if (inst == 0) exp_q_a.push_back(ent);
            else           exp_q_b.push_back(ent);
          end
        end
        m_bidx[inst]++;
        if (m_bidx[inst] == plb) begin
          m_bidx[inst]  = 0;
          m_phase[inst] = 1;
        end
      end
      1: begin
        if (b == 8'h0D) m_phase[inst] = 2;
        else begin push_ev(inst, 2'd2); m_phase[inst] = 3; m_seen0[inst] = 0; end
      end
      2: begin
        if (b == 8'h0A) begin push_ev(inst, 2'd1); m_phase[inst] = 0; end
        else begin push_ev(inst, 2'd2); m_phase[inst] = 3; m_seen0[inst] = 0; end
      end
      default: begin
        if (b == 8'h0D) m_seen0[inst] = 1;
        else if (b == 8'h0A && m_seen0[inst] == 1) begin
          m_phase[inst] = 0; m_bidx[inst] = 0; m_seen0[inst] = 0;
        end else m_seen0[inst] = 0;
      end
    endcase
  endtask

  // ---------------- monitors ----------------
  logic       a_stall = 1'b0, b_stall = 1'b0;
  logic [31:0] a_prev, b_prev;

  initial forever begin
    @(negedge clk);
    if (rst) a_stall = 1'b0;
    else begin
      if (a_stall) begin
        check("a_hold_valid", 32'(a_valid_o), 32'd1);
        check("a_hold_data", {23'd0, a_last_o, 7'd0, a_unpacked_o}, a_prev);
      end
      if (a_valid_o && a_ready_i) begin
        check("a_elem_expected", 32'(exp_q_a.size() != 0), 32'd1);
        if (exp_q_a.size() != 0)
          check("a_elem", {23'd0, a_last_o, 7'd0, a_unpacked_o}, 32'(exp_q_a.pop_front()));
        if (a_last_o) a_last_cyc = cyc;
      end
      a_stall = a_valid_o && !a_ready_i;
      a_prev  = {23'd0, a_last_o, 7'd0, a_unpacked_o};
      if (a_ok || a_err) begin
        check("a_event_expected", 32'(ev_q_a.size() != 0), 32'd1);
        if (ev_q_a.size() != 0) check("a_event", 32'({a_err, a_ok}), 32'(ev_q_a.pop_front()));
        if (a_ok) a_ok_cyc = cyc;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) b_stall = 1'b0;
    else begin
      if (b_stall) begin
        check("b_hold_valid", 32'(b_valid_o), 32'd1);
        check("b_hold_data", {23'd0, b_last_o, 6'd0, b_unpacked_o}, b_prev);
      end
      if (b_valid_o && b_ready_i) begin
        check("b_elem_expected", 32'(exp_q_b.size() != 0), 32'd1);
        if (exp_q_b.size() != 0)
          check("b_elem", {23'd0, b_last_o, 6'd0, b_unpacked_o}, 32'(exp_q_b.pop_front()));
      end
      b_stall = b_valid_o && !b_ready_i;
      b_prev  = {23'd0, b_last_o, 6'd0, b_unpacked_o};
      if (b_ok || b_err) begin
        check("b_event_expected", 32'(ev_q_b.size() != 0), 32'd1);
        if (ev_q_b.size() != 0) check("b_event", 32'({b_err, b_ok}), 32'(ev_q_b.pop_front()));
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  // mode 0: always ready, 1: alternating, 2: random (mostly ready)
  int a_rmode = 0, b_rmode = 0;
  initial begin
    a_ready_i = 1'b1;
    b_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (a_rmode)
        0: a_ready_i = 1'b1;
        1: a_ready_i = ~a_ready_i;
        default: a_ready_i = ($urandom_range(0, 3) != 0);
      endcase
      case (b_rmode)
        0: b_ready_i = 1'b1;
        1: b_ready_i = ~b_ready_i;
        default: b_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] stim_q[$];

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input int inst, input logic [7:0] b);
    int  n;
    bit  ok;
    n = 0; ok = 0;
    if (inst == 0) begin a_data_i = b; a_valid_i = 1'b1; end
    else           begin b_data_i = b; b_valid_i = 1'b1; end
    while (!ok && n < 200) begin
      @(negedge clk);
      if (((inst == 0) ? a_ready_o : b_ready_o) == 1'b1) ok = 1;
      else n++;
    end
    check((inst == 0) ? "a_accept" : "b_accept", 32'(ok), 32'd1);
    if (ok) acc_cyc = cyc;
    @(posedge clk);
    if (ok) model_accept(inst, b);
    #1;
    if (inst == 0) a_valid_i = 1'b0;
    else           b_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int inst);
    int n;
    n = 0;
    while (((inst == 0) ? a_valid_o : b_valid_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check((inst == 0) ? "a_drain" : "b_drain", 32'((inst == 0) ? a_valid_o : b_valid_o), 32'd0);
    @(posedge clk); #1;
  endtask

  // Sends stim_q; lets the payload drain before any tail pair that is not
  // 0D,0A so the error's counter restart never overlaps a draining frame.
  int first_acc = -1;
  task automatic send_stim(input int inst, input int gap_max);
    for (int i = 0; i < stim_q.size(); i++) begin
      if (m_phase[inst] == 1 &&
          !(stim_q[i] == 8'h0D && i + 1 < stim_q.size() && stim_q[i+1] == 8'h0A))
        wait_drain(inst);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      send_byte(inst, stim_q[i]);
      if (i == 0) first_acc = acc_cyc;
    end
    stim_q.delete();
  endtask

  task automatic finish_segment(input string tag, input int inst);
    wait_drain(inst);
    idle(4);
    check({tag, "_elems_left"}, 32'((inst == 0) ? exp_q_a.size() : exp_q_b.size()), 32'd0);
    check({tag, "_events_left"}, 32'((inst == 0) ? ev_q_a.size() : ev_q_b.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_ready"},  32'(a_ready_o),    32'd1);
    check({tag, "_a_valid"},  32'(a_valid_o),    32'd0);
    check({tag, "_a_data"},   32'(a_unpacked_o), 32'd0);
    check({tag, "_a_last"},   32'(a_last_o),     32'd0);
    check({tag, "_a_events"}, 32'({a_ok, a_err}), 32'd0);
    check({tag, "_b_ready"},  32'(b_ready_o),    32'd1);
    check({tag, "_b_valid"},  32'(b_valid_o),    32'd0);
    check({tag, "_b_data"},   32'(b_unpacked_o), 32'd0);
    check({tag, "_b_events"}, 32'({b_ok, b_err}), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: run did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, r, nj;
    rst = 1'b1;
    a_valid_i = 1'b0; a_data_i = '0;
    b_valid_i = 1'b0; b_data_i = '0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    @(posedge clk); #1;

    // Clean frame, full rate: elements back to back, ok one cycle after tail.
    a_rmode = 0;
    stim_q = '{8'hA5, 8'h03, 8'h0D, 8'h0A};
    send_stim(0, 0);
    finish_segment("s1", 0);
    check("s1_last_latency", 32'(a_last_cyc - first_acc), 32'd10);
    check("s1_ok_latency",   32'(a_ok_cyc - first_acc),   32'd11);

    // Same frame under alternating backpressure.
    a_rmode = 1;
    stim_q = '{8'hA5, 8'h03, 8'h0D, 8'h0A};
    send_stim(0, 0);
    finish_segment("s2", 0);

    // Bad second tail byte, hunt, resync, then a clean frame.
    a_rmode = 0;
    stim_q = '{8'hFF, 8'h01, 8'h0D, 8'h0B, 8'h55, 8'h0D, 8'h0D, 8'h0A,
               8'hA5, 8'h03, 8'h0D, 8'h0A};
    send_stim(0, 0);
    finish_segment("s3", 0);

    // Reset after three elements of the first byte have drained.
    a_rmode = 0;
    send_byte(0, 8'hA5);
    n = 0;
    while (exp_q_a.size() > 5 && n < 50) begin @(negedge clk); #1; n++; end
    check("s4_drained_three", 32'(exp_q_a.size()), 32'd5);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("s4_reset");
    exp_q_a.delete(); ev_q_a.delete();
    model_reset(0);
    model_reset(1);
    @(posedge clk); #1;
    rst = 1'b0;
    stim_q = '{8'h0F, 8'h01, 8'h0D, 8'h0A};
    send_stim(0, 0);
    finish_segment("s4", 0);

    // Multi-bit elements on instance B.
    b_rmode = 0;
    stim_q = '{8'hE4, 8'hB1, 8'h0D, 8'h0A};
    send_stim(1, 0);
    finish_segment("s5", 1);

    // Random frames on A: random payload, random ready, occasional bad tails
    // followed by junk and a resync pair.
    a_rmode = 2;
    for (int f = 0; f < 25; f++) begin
      stim_q.push_back(8'($urandom_range(0, 255)));
      stim_q.push_back(8'($urandom_range(0, 255)));
      r = $urandom_range(0, 3);
      if (r <= 1) begin
        stim_q.push_back(8'h0D); stim_q.push_back(8'h0A);
      end else begin
        if (r == 2) stim_q.push_back(8'h0D);
        else        stim_q.push_back(8'($urandom_range(0, 255)));
        stim_q.push_back(8'($urandom_range(0, 255)));
        nj = $urandom_range(0, 3);
        for (int j = 0; j < nj; j++) begin
          case ($urandom_range(0, 3))
            0: stim_q.push_back(8'h0D);
            1: stim_q.push_back(8'h0A);
            2: stim_q.push_back(8'h55);
            default: stim_q.push_back(8'($urandom_range(0, 255)));
          endcase
        end
        stim_q.push_back(8'h0D); stim_q.push_back(8'h0A);
      end
      send_stim(0, 2);
    end
    finish_segment("rand_a", 0);

    // Random frames on B with random backpressure.
    b_rmode = 2;
    for (int f = 0; f < 8; f++) begin
      stim_q.push_back(8'($urandom_range(0, 255)));
      stim_q.push_back(8'($urandom_range(0, 255)));
      stim_q.push_back(8'h0D);
      stim_q.push_back(8'h0A);
      send_stim(1, 1);
    end
    finish_segment("rand_b", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
